// File: rtl/seg7_page_scheduler.sv
// seg7_page_scheduler: rotates TEMP/DUTY/ALERT display pages and converts their operands to BCD.
module seg7_page_scheduler #(
    parameter int DWELL_CYCLES = 200_000_000,
    parameter int DW_W = $clog2(DWELL_CYCLES)
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [7:0]  c_data,
    input  logic [7:0]  f_data,
    input  logic [7:0]  duty_data,
    input  logic        alert_req,
    input  logic [7:0]  alert_code,
    output logic        alert_ack,
    output logic [1:0]  page_id,
    output logic [11:0] bcd_left,
    output logic [11:0] bcd_right,
    output logic        disp_valid
);
    typedef enum logic [1:0] {LOAD, CONV_L, CONV_R, SHOW} state_t;
    localparam logic [1:0] TEMP = 2'd0, DUTY = 2'd1, ALERT = 2'd2;
    state_t state;
    logic [1:0] target, resume;
    logic [DW_W-1:0] dwell;
    logic [2:0] bit_cnt;
    logic [19:0] work, step;
    logic [7:0] right_bin;
    logic [11:0] left_bcd;
    logic [3:0] adj_h, adj_t, adj_o;
    logic [1:0] succ;
    // One double-dabble step on {hundreds, tens, ones, binary}; shared by both conversions.
    always_comb begin
        adj_h = work[19:16] >= 4'd5 ? work[19:16] + 4'd3 : work[19:16];
        adj_t = work[15:12] >= 4'd5 ? work[15:12] + 4'd3 : work[15:12];
        adj_o = work[11:8] >= 4'd5 ? work[11:8] + 4'd3 : work[11:8];
        step = {adj_h, adj_t, adj_o, work[7:0]} << 1;
        succ = target == TEMP ? DUTY : TEMP;
    end
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            target <= TEMP;
            resume <= DUTY;
            dwell <= '0;
            bit_cnt <= '0;
            work <= '0;
            right_bin <= '0;
            left_bcd <= '0;
            page_id <= TEMP;
            bcd_left <= '0;
            bcd_right <= '0;
            disp_valid <= 1'b0;
            alert_ack <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            alert_ack <= 1'b0;
            case (state)
                LOAD: begin
                    work <= {12'd0, target == TEMP ? c_data : target == DUTY ? duty_data : alert_code};
                    right_bin <= target == TEMP ? f_data : 8'd0;
                    bit_cnt <= '0;
                    state <= CONV_L;
                end
                CONV_L: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    work <= bit_cnt == 3'd7 ? {12'd0, right_bin} : step;
                    if (bit_cnt == 3'd7) begin
                        left_bcd <= step[19:8];
                        state <= CONV_R;
                    end
                end
                CONV_R: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    work <= step;
                    if (bit_cnt == 3'd7) begin
                        page_id <= target;
                        bcd_left <= left_bcd;
                        bcd_right <= step[19:8];
                        disp_valid <= 1'b1;
                        alert_ack <= target == ALERT;
                        dwell <= '0;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (alert_req && target != ALERT) begin
                        dwell <= '0;
                        resume <= succ;
                        target <= ALERT;
                        state <= LOAD;
                    end else if (dwell == DW_W'(DWELL_CYCLES - 1)) begin
                        dwell <= '0;
                        target <= target == ALERT ? (alert_req ? ALERT : resume) : succ;
                        state <= LOAD;
                    end else begin
                        dwell <= dwell + DW_W'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_page_scheduler.sv
// tb_seg7_page_scheduler: scoreboard bench with a cycle-level page-schedule reference model.
module tb_seg7_page_scheduler;
    localparam int DWELL = 20;
    logic clk_100MHz = 1'b0, reset = 1'b1, alert_req = 1'b0;
    logic [7:0] c_data = '0, f_data = '0, duty_data = '0, alert_code = '0;
    logic alert_ack, disp_valid;
    logic [1:0] page_id;
    logic [11:0] bcd_left, bcd_right;

    seg7_page_scheduler #(.DWELL_CYCLES(DWELL)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .c_data(c_data), .f_data(f_data),
        .duty_data(duty_data), .alert_req(alert_req), .alert_code(alert_code),
        .alert_ack(alert_ack), .page_id(page_id), .bcd_left(bcd_left),
        .bcd_right(bcd_right), .disp_valid(disp_valid)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {int due; int page; logic [11:0] l; logic [11:0] r;} frame_t;
    frame_t q[$];
    frame_t e;
    int tests = 0, fails = 0;
    int edge_n = 0, load_edge = 1, show_start = -1000, m_page = 0, m_resume = 1;
    logic [1:0] last_page = '0;
    logic [11:0] last_l = '0, last_r = '0;

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Reference model: schedule expressed as LOAD edges, a 17-edge conversion and a dwell window.
    always @(posedge clk_100MHz) begin
        edge_n++;
        if (reset) begin
            q.delete();
            load_edge = edge_n + 1;
            m_page = 0;
            m_resume = 1;
            show_start = -1000;
        end else if (edge_n == load_edge) begin
            q.push_back('{edge_n + 16, m_page,
                bcd(m_page == 0 ? int'(c_data) : m_page == 1 ? int'(duty_data) : int'(alert_code)),
                bcd(m_page == 0 ? int'(f_data) : 0)});
            show_start = edge_n + 16;
        end else if (edge_n > show_start && edge_n <= show_start + DWELL) begin
            if (alert_req && m_page != 2) begin
                m_resume = m_page == 0 ? 1 : 0;
                m_page = 2;
                load_edge = edge_n + 1;
            end else if (edge_n == show_start + DWELL) begin
                m_page = m_page == 2 ? (alert_req ? 2 : m_resume) : (m_page == 0 ? 1 : 0);
                load_edge = edge_n + 1;
            end
        end
    end

    always @(negedge clk_100MHz) begin
        if (reset) begin
            check("reset_outputs", int'({page_id, bcd_left, bcd_right, disp_valid, alert_ack}), 0);
            last_page = '0;
            last_l = '0;
            last_r = '0;
        end else if (disp_valid) begin
            if (q.size() == 0) check("spurious_frame", 1, 0);
            else begin
                e = q.pop_front();
                check("frame_edge", edge_n, e.due);
                check("page_id", int'(page_id), e.page);
                check("bcd_left", int'(bcd_left), int'(e.l));
                check("bcd_right", int'(bcd_right), int'(e.r));
                check("alert_ack", int'(alert_ack), int'(e.page == 2));
                last_page = 2'(e.page);
                last_l = e.l;
                last_r = e.r;
            end
        end else begin
            check("hold", int'({page_id, bcd_left, bcd_right, alert_ack}),
                  int'({last_page, last_l, last_r, 1'b0}));
            if (q.size() > 0 && edge_n > q[0].due) begin
                check("frame_timeout", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #2;
        end
    endtask

    task automatic wait_page(input int p, input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk_100MHz);
            if (disp_valid && page_id == 2'(p)) break;
        end
        check(nm, int'(k < 200), 1);
        step(1);
    endtask

    task automatic wait_load(input int pg, input int off, input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            if (edge_n == load_edge + off && (pg < 0 || m_page == pg)) break;
            step(1);
        end
        check(nm, int'(k < 200), 1);
    endtask

    initial begin
        c_data = 8'd25;
        f_data = 8'd77;
        duty_data = 8'd100;
        step(3);
        reset = 1'b0;
        wait_page(0, "first_temp");
        wait_page(1, "duty_100");
        wait_page(0, "temp_again");
        wait_load(0, 0, "temp_load");
        c_data = 8'd30;
        wait_page(0, "temp_old_c");
        wait_page(0, "temp_new_c");
        wait_page(1, "duty_before_alert");
        step(5);
        alert_req = 1'b1;
        alert_code = 8'd255;
        wait_page(2, "alert_255");
        alert_req = 1'b0;
        wait_page(0, "resume_after_duty");
        alert_code = 8'd7;
        alert_req = 1'b1;
        wait_page(2, "alert_7");
        alert_code = 8'd9;
        wait_page(2, "alert_9");
        alert_req = 1'b0;
        step(60);
        wait_load(-1, 3, "conv_l_reached");
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        wait_page(0, "temp_after_reset");
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) begin
                c_data = 8'($urandom_range(0, 255));
                f_data = 8'($urandom_range(0, 255));
                duty_data = 8'($urandom_range(0, 100));
                alert_code = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 59) == 0) alert_req = ~alert_req;
            reset = $urandom_range(0, 999) == 0;
            step(1);
        end
        reset = 1'b0;
        alert_req = 1'b0;
        step(60);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
